// File: rtl/microcode_sequencer_if.sv
// Handshake/bus bundle for the microcode sequencer.
// Host (master) side drives the control inputs and the loader; the sequencer (slave) side drives status.
interface microcode_sequencer_if #(
    parameter int AW     = 8,
    parameter int CW     = 22,
    parameter int NFLAGS = 4,
    parameter int WW     = 35,
    parameter int PW     = 2
);
    logic              start;
    logic [AW-1:0]     opcode;
    logic [NFLAGS-1:0] flags;
    logic              ld_we;
    logic [AW-1:0]     ld_addr;
    logic [WW-1:0]     ld_data;
    logic [CW-1:0]     mir;
    logic              mir_valid;
    logic [AW-1:0]     upc;
    logic [PW-1:0]     phase;
    logic              busy;
    logic              halted;
    logic              err;

    modport master (
        output start, opcode, flags, ld_we, ld_addr, ld_data,
        input  mir, mir_valid, upc, phase, busy, halted, err
    );

    modport slave (
        input  start, opcode, flags, ld_we, ld_addr, ld_data,
        output mir, mir_valid, upc, phase, busy, halted, err
    );
endinterface

// File: rtl/microcode_sequencer.sv
// Microprogram sequencer: writable control store, micro-PC and multi-phase step timer.
// Each step fetches one word and picks the next address by jump, dispatch, branch or halt.
module microcode_sequencer #(
    parameter int CW         = 22,
    parameter int AW         = 8,
    parameter int DEPTH      = 256,
    parameter int NFLAGS     = 4,
    parameter int PHASES     = 4,
    parameter int START_ADDR = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    microcode_sequencer_if.slave  bus
);
    localparam int FSW = $clog2(NFLAGS);
    localparam int FLW = 1 << FSW;
    localparam int WW  = 2 + FSW + 1 + AW + CW;
    localparam int PW  = (PHASES > 1) ? $clog2(PHASES) : 1;

    localparam logic [FLW-1:0] FVALID = FLW'({NFLAGS{1'b1}});
    localparam logic [AW:0]    DEPTH_X = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]  START_A = AW'(START_ADDR);
    localparam logic [PW-1:0]  PH_LAST = PW'(PHASES - 1);

    localparam logic [1:0] SQ_JUMP = 2'b00;
    localparam logic [1:0] SQ_DISP = 2'b01;
    localparam logic [1:0] SQ_BRAN = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_HALT = 2'b10
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  mir_q, mir_d;
    logic           mir_valid_q, mir_valid_d;
    logic [AW-1:0]  upc_q, upc_d;
    logic [PW-1:0]  phase_q, phase_d;
    logic           halted_q, halted_d;
    logic           err_q, err_d;

    logic [WW-1:0]  store [DEPTH];

    logic [WW-1:0]  w;
    logic [1:0]     w_seq;
    logic [FSW-1:0] w_fsel;
    logic           w_pol;
    logic [AW-1:0]  w_next;
    logic [CW-1:0]  w_ctrl;
    logic [FLW-1:0] flags_ext;
    logic           taken;
    logic [AW:0]    nxt;
    logic           nxt_bad;
    logic           last;
    logic           wr_ok;

    assign w      = store[upc_q];
    assign w_ctrl = w[CW-1:0];
    assign w_next = w[CW +: AW];
    assign w_pol  = w[CW+AW];
    assign w_fsel = w[CW+AW+1 +: FSW];
    assign w_seq  = w[WW-1 -: 2];

    // Flag selectors past NFLAGS read as "never taken" via the valid mask.
    assign flags_ext = FLW'(bus.flags);
    assign taken     = FVALID[w_fsel] && (flags_ext[w_fsel] == w_pol);
    assign last      = (phase_q == PH_LAST);
    assign wr_ok     = bus.ld_we && (state_q != S_RUN)
                       && ({1'b0, bus.ld_addr} < DEPTH_X);

    // Next micro-address of the word at upc, one bit wider to catch overflow.
    always_comb begin
        nxt = {1'b0, upc_q};
        unique case (w_seq)
            SQ_JUMP: nxt = {1'b0, w_next};
            SQ_DISP: nxt = {1'b0, bus.opcode};
            SQ_BRAN: nxt = taken ? {1'b0, w_next}
                                 : {1'b0, upc_q} + (AW+1)'(1);
            default: nxt = {1'b0, upc_q};
        endcase
    end

    assign nxt_bad = (nxt >= DEPTH_X);

    // Control-store loader; frozen while the program runs, never reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            store[bus.ld_addr] <= bus.ld_data;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mir_q       <= '0;
            mir_valid_q <= 1'b0;
            upc_q       <= START_A;
            phase_q     <= '0;
            halted_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mir_q       <= mir_d;
            mir_valid_q <= mir_valid_d;
            upc_q       <= upc_d;
            phase_q     <= phase_d;
            halted_q    <= halted_d;
            err_q       <= err_d;
        end
    end

    // Next-state: start handling, phase timer and fetch on the last phase.
    always_comb begin
        state_d     = state_q;
        mir_d       = mir_q;
        mir_valid_d = 1'b0;
        upc_d       = upc_q;
        phase_d     = phase_q;
        halted_d    = halted_q;
        err_d       = err_q;
        unique case (state_q)
            S_IDLE, S_HALT: begin
                if (bus.start) begin
                    state_d  = S_RUN;
                    upc_d    = START_A;
                    phase_d  = '0;
                    halted_d = 1'b0;
                    err_d    = 1'b0;
                end
            end
            S_RUN: begin
                if (!last) begin
                    phase_d = phase_q + PW'(1);
                end else begin
                    phase_d     = '0;
                    mir_d       = w_ctrl;
                    mir_valid_d = 1'b1;
                    if (w_seq == 2'b11) begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end else if (nxt_bad) begin
                        err_d   = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        upc_d = nxt[AW-1:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.mir       = mir_q;
    assign bus.mir_valid = mir_valid_q;
    assign bus.upc       = upc_q;
    assign bus.phase     = phase_q;
    assign bus.busy      = (state_q == S_RUN);
    assign bus.halted    = halted_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed bench for microcode_sequencer: a 256-word/4-phase instance and
// a 16-word/1-phase/3-flag instance share clock and reset.
module tb_microcode_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    microcode_sequencer_if #(.AW(8), .CW(22), .NFLAGS(4), .WW(35), .PW(2)) b1 ();
    microcode_sequencer_if #(.AW(8), .CW(22), .NFLAGS(3), .WW(35), .PW(1)) b2 ();

    microcode_sequencer #(
        .CW(22), .AW(8), .DEPTH(256), .NFLAGS(4), .PHASES(4), .START_ADDR(0)
    ) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    microcode_sequencer #(
        .CW(22), .AW(8), .DEPTH(16), .NFLAGS(3), .PHASES(1), .START_ADDR(0)
    ) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b2)
    );

    function automatic logic [34:0] mk(input logic [1:0] seq, input logic [1:0] fsel,
                                       input logic pol, input logic [7:0] nx,
                                       input logic [21:0] ctrl);
        return {seq, fsel, pol, nx, ctrl};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load1(input logic [7:0] a, input logic [34:0] d);
        b1.ld_we = 1'b1; b1.ld_addr = a; b1.ld_data = d;
        tick();
        b1.ld_we = 1'b0;
    endtask

    task automatic load2(input logic [7:0] a, input logic [34:0] d);
        b2.ld_we = 1'b1; b2.ld_addr = a; b2.ld_data = d;
        tick();
        b2.ld_we = 1'b0;
    endtask

    task automatic start1();
        b1.start = 1'b1;
        tick();
        b1.start = 1'b0;
    endtask

    task automatic start2();
        b2.start = 1'b1;
        tick();
        b2.start = 1'b0;
    endtask

    // Start, check upc after second fetch, then the halting word's ctrl.
    task automatic br_run(input string tag, input logic [3:0] fl,
                          input logic [7:0] eupc, input logic [21:0] emir);
        b1.flags = fl;
        start1();
        tick(8);
        chk({tag, "_upc"}, b1.upc, eupc);
        tick(4);
        chk({tag, "_mir"}, b1.mir, emir);
        chk({tag, "_halt"}, b1.halted, 1);
    endtask

    initial begin
        b1.start = 0; b1.opcode = 0; b1.flags = 0;
        b1.ld_we = 0; b1.ld_addr = 0; b1.ld_data = 0;
        b2.start = 0; b2.opcode = 0; b2.flags = 0;
        b2.ld_we = 0; b2.ld_addr = 0; b2.ld_data = 0;
        rst_n = 1'b0;
        tick();
        chk("rst_mir", b1.mir, 0);
        chk("rst_mv", b1.mir_valid, 0);
        chk("rst_upc", b1.upc, 0);
        chk("rst_phase", b1.phase, 0);
        chk("rst_busy", b1.busy, 0);
        chk("rst_halted", b1.halted, 0);
        chk("rst_err", b1.err, 0);
        chk("rst2_upc", b2.upc, 0);
        rst_n = 1'b1;
        tick();

        // jump then halt
        load1(8'h00, mk(2'b00, 2'd0, 1'b0, 8'h02, 22'h1));
        load1(8'h02, mk(2'b11, 2'd0, 1'b0, 8'h00, 22'h3));
        start1();
        chk("t1_busy", b1.busy, 1);
        chk("t1_ph0", b1.phase, 0);
        tick(3);
        chk("t1_ph3", b1.phase, 3);
        chk("t1_mv_early", b1.mir_valid, 0);
        tick();
        chk("t1_mv1", b1.mir_valid, 1);
        chk("t1_mir1", b1.mir, 22'h1);
        chk("t1_upc1", b1.upc, 8'h02);
        tick();
        chk("t1_mv_pulse", b1.mir_valid, 0);
        chk("t1_mir_hold", b1.mir, 22'h1);
        tick(3);
        chk("t1_mv2", b1.mir_valid, 1);
        chk("t1_mir2", b1.mir, 22'h3);
        chk("t1_halted", b1.halted, 1);
        chk("t1_busy_h", b1.busy, 0);
        chk("t1_upc_h", b1.upc, 8'h02);

        // dispatch on opcode
        load1(8'h00, mk(2'b00, 2'd0, 1'b0, 8'h05, 22'h0));
        load1(8'h05, mk(2'b01, 2'd0, 1'b0, 8'h00, 22'h5));
        load1(8'h0A, mk(2'b11, 2'd0, 1'b0, 8'h00, 22'h2A));
        b1.opcode = 8'h0A;
        start1();
        chk("t2_hclr", b1.halted, 0);
        tick(8);
        chk("t2_upc", b1.upc, 8'h0A);
        chk("t2_mir5", b1.mir, 22'h5);
        tick(4);
        chk("t2_mir", b1.mir, 22'h2A);
        chk("t2_halted", b1.halted, 1);
        chk("t2_upc_h", b1.upc, 8'h0A);

        // conditional branch
        load1(8'h00, mk(2'b00, 2'd0, 1'b0, 8'h10, 22'h0));
        load1(8'h10, mk(2'b10, 2'd0, 1'b1, 8'h20, 22'h10));
        load1(8'h20, mk(2'b11, 2'd0, 1'b0, 8'h00, 22'h20));
        load1(8'h11, mk(2'b11, 2'd0, 1'b0, 8'h00, 22'h11));
        br_run("t3_p1_z1", 4'b0001, 8'h20, 22'h20);
        br_run("t3_p1_z0", 4'b0000, 8'h11, 22'h11);
        load1(8'h10, mk(2'b10, 2'd0, 1'b0, 8'h20, 22'h10));
        br_run("t3_p0_z0", 4'b0000, 8'h20, 22'h20);
        br_run("t3_p0_z1", 4'b0001, 8'h11, 22'h11);
        load1(8'h10, mk(2'b10, 2'd2, 1'b1, 8'h20, 22'h10));
        br_run("t3_f2_set", 4'b0100, 8'h20, 22'h20);
        br_run("t3_f2_clr", 4'b1011, 8'h11, 22'h11);

        // writes during RUN are dropped
        load1(8'h00, mk(2'b00, 2'd0, 1'b0, 8'h30, 22'h7));
        load1(8'h30, mk(2'b11, 2'd0, 1'b0, 8'h00, 22'h30));
        start1();
        b1.ld_we = 1'b1; b1.ld_addr = 8'h00;
        b1.ld_data = mk(2'b11, 2'd0, 1'b0, 8'h00, 22'h155);
        tick(4);
        b1.ld_we = 1'b0;
        chk("t5_mir", b1.mir, 22'h7);
        chk("t5_upc", b1.upc, 8'h30);
        tick(4);
        chk("t5_halt_mir", b1.mir, 22'h30);
        start1();
        tick(4);
        chk("t5_rerun", b1.mir, 22'h7);
        tick(4);
        chk("t5_rerun_h", b1.halted, 1);

        // async reset mid-RUN
        start1();
        tick(2);
        chk("t6_ph2", b1.phase, 2);
        chk("t6_busy", b1.busy, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_mir", b1.mir, 0);
        chk("t6_upc", b1.upc, 0);
        chk("t6_phase", b1.phase, 0);
        chk("t6_busy0", b1.busy, 0);
        chk("t6_halted", b1.halted, 0);
        chk("t6_mv", b1.mir_valid, 0);
        #2 rst_n = 1'b1;
        start1();
        tick(4);
        chk("t6_keep", b1.mir, 22'h7);
        chk("t6_keep_upc", b1.upc, 8'h30);

        // small store, 1 phase, overflow and fsel out of range
        load2(8'h00, mk(2'b00, 2'd0, 1'b0, 8'h0F, 22'h1));
        load2(8'h0F, mk(2'b10, 2'd3, 1'b0, 8'h03, 22'hF));
        start2();
        chk("t4_busy", b2.busy, 1);
        tick();
        chk("t4_mir0", b2.mir, 22'h1);
        chk("t4_upc0", b2.upc, 8'h0F);
        chk("t4_ph", b2.phase, 0);
        tick();
        chk("t4_err", b2.err, 1);
        chk("t4_halted", b2.halted, 0);
        chk("t4_busy0", b2.busy, 0);
        chk("t4_upc", b2.upc, 8'h0F);
        chk("t4_mir", b2.mir, 22'hF);
        start2();
        chk("t4_rerun", b2.busy, 1);
        chk("t4_errclr", b2.err, 0);
        tick(2);
        chk("t4_err2", b2.err, 1);

        // out-of-range load ignored
        load2(8'h00, mk(2'b00, 2'd0, 1'b0, 8'h03, 22'h1));
        load2(8'h03, mk(2'b11, 2'd0, 1'b0, 8'h00, 22'h33));
        load2(8'h13, mk(2'b11, 2'd0, 1'b0, 8'h00, 22'h99));
        start2();
        tick(2);
        chk("t7_mir", b2.mir, 22'h33);
        chk("t7_halted", b2.halted, 1);

        // load and start on the same edge
        b2.ld_we = 1'b1; b2.ld_addr = 8'h00;
        b2.ld_data = mk(2'b11, 2'd0, 1'b0, 8'h00, 22'h44);
        b2.start = 1'b1;
        tick();
        b2.ld_we = 1'b0; b2.start = 1'b0;
        chk("t8_busy", b2.busy, 1);
        tick();
        chk("t8_mir", b2.mir, 22'h44);
        chk("t8_halted", b2.halted, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
